input_tile_loader: RTL and testbench

//  Writer side of the ping-pong input buffer. Accepts a byte stream of image-tile data, packs it into

---
 rtl/input_tile_loader_if.sv | 36 +++
 rtl/input_tile_loader.sv | 163 ++++++++++++++++
 tb/tb_input_tile_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_tile_loader_if.sv
// input_tile_loader_if
// Bundles the byte stream, the SRAM write port and the array handshake of the
// input tile loader. The master modport is the loader itself; the slave
// modport is the surrounding system (stream source, memory, systolic array).
interface input_tile_loader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int SRAM_WIDTH = 32
);
   localparam int BYTES = SRAM_WIDTH / 8;

   logic                  s_valid;
   logic                  s_ready;
   logic [7:0]            s_data;
   logic                  s_last;
   logic                  input_wr_en;
   logic [ADDR_WIDTH-1:0] input_wr_addr;
   logic [SRAM_WIDTH-1:0] input_wr_data;
   logic [BYTES-1:0]      input_wr_mask;
   logic                  loader_bank_sel;
   logic                  array_bank_sel;
   logic                  tile_valid;
   logic [ADDR_WIDTH:0]   tile_words;
   logic                  array_done;

   modport master (
      input  s_valid, s_data, s_last, array_done,
      output s_ready, input_wr_en, input_wr_addr, input_wr_data, input_wr_mask,
             loader_bank_sel, array_bank_sel, tile_valid, tile_words
   );

   modport slave (
      output s_valid, s_data, s_last, array_done,
      input  s_ready, input_wr_en, input_wr_addr, input_wr_data, input_wr_mask,
             loader_bank_sel, array_bank_sel, tile_valid, tile_words
   );
endinterface

// File: rtl/input_tile_loader.sv
// input_tile_loader
// Writer side of the ping-pong input buffer. Packs a byte stream little-endian
// into SRAM words, writes them into the bank selected by loader_bank_sel, marks
// banks FULL at tile end and offers them to the systolic array, which frees
// them again with array_done.
// Optional build macro: LOADER_ZERO_PAD_EN -- a partial last word is written
// with an all-ones mask and zero-filled unused bytes instead of a byte mask
// covering only the filled bytes.
module input_tile_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int SRAM_WIDTH = 32,
   parameter int TILE_WORDS = 64
) (
   input logic                  clk,
   input logic                  rst_n,
   input_tile_loader_if.master  bus
);
   localparam int BYTES = SRAM_WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(TILE_WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]            r_state;
   logic [BCW-1:0]        r_byteCnt;
   logic [ADDR_WIDTH-1:0] r_wordCnt;
   logic [SRAM_WIDTH-1:0] r_wordBuf;
   logic [ADDR_WIDTH-1:0] r_wrAddr;
   logic [SRAM_WIDTH-1:0] r_wrData;
   logic [BYTES-1:0]      r_wrMask;
   logic                  r_loaderSel;
   logic                  r_arraySel;
   logic [1:0]            r_full;
   logic [ADDR_WIDTH:0]   r_count [2];

   logic                  w_ready;
   logic                  w_accept;
   logic                  w_wordDone;
   logic                  w_tileEnd;
   logic                  w_tileValid;
   logic                  w_release;
   logic                  w_otherSel;
   logic                  w_otherFree;
   logic [SRAM_WIDTH-1:0] w_packed;
   logic [BYTES-1:0]      w_mask;

   assign w_ready     = (r_state == S_FILL);
   assign w_accept    = bus.s_valid & w_ready;
   assign w_wordDone  = w_accept & ((r_byteCnt == LAST_BYTE) | bus.s_last);
   assign w_tileEnd   = w_wordDone & ((r_wordCnt == LAST_WORD) | bus.s_last);
   assign w_tileValid = r_full[r_arraySel];
   assign w_release   = bus.array_done & w_tileValid;
   assign w_otherSel  = ~r_loaderSel;
   // The other bank counts as free if it is EMPTY now or the array is handing it back this cycle.
   assign w_otherFree = ~r_full[w_otherSel] | (w_release & (r_arraySel == w_otherSel));

   // Merge the incoming byte into the word under construction and derive the byte mask of the word.
   always_comb begin
      w_packed = r_wordBuf;
      w_mask   = '0;
      for (int k = 0; k < BYTES; k++) begin
         if (r_byteCnt == BCW'(k)) begin
            w_packed[8*k +: 8] = bus.s_data;
         end
      end
`ifdef LOADER_ZERO_PAD_EN
      w_mask = '1;
`else
      for (int k = 0; k < BYTES; k++) begin
         w_mask[k] = (BCW'(k) <= r_byteCnt);
      end
`endif
   end

   // Byte packing and the write-payload register; the word buffer is cleared after every issued word so unfilled bytes read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byteCnt <= '0;
         r_wordCnt <= '0;
         r_wordBuf <= '0;
         r_wrAddr  <= '0;
         r_wrData  <= '0;
         r_wrMask  <= '0;
      end else begin
         if (w_accept) begin
            if (w_wordDone) begin
               r_byteCnt <= '0;
               r_wordBuf <= '0;
            end else begin
               r_byteCnt <= r_byteCnt + 1'b1;
               r_wordBuf <= w_packed;
            end
         end
         if (w_wordDone) begin
            r_wrAddr  <= r_wordCnt;
            r_wrData  <= w_packed;
            r_wrMask  <= w_mask;
            r_wordCnt <= w_tileEnd ? '0 : r_wordCnt + 1'b1;
         end
      end
   end

   // Loader FSM, bank FULL/EMPTY tracking and the array-side bank pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_loaderSel <= 1'b0;
         r_arraySel  <= 1'b1;
         r_full      <= 2'b00;
         r_count[0]  <= '0;
         r_count[1]  <= '0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FILL;
            S_FILL: begin
               if (w_tileEnd) begin
                  if (w_otherFree) begin
                     r_loaderSel <= w_otherSel;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (w_otherFree) begin
                  r_state     <= S_FILL;
                  r_loaderSel <= w_otherSel;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_release) begin
            r_full[r_arraySel]  <= 1'b0;
            r_count[r_arraySel] <= '0;
         end
         if (w_tileEnd) begin
            r_full[r_loaderSel]  <= 1'b1;
            r_count[r_loaderSel] <= {1'b0, r_wordCnt} + 1'b1;
         end

         if (w_release) begin
            r_arraySel <= ~r_arraySel;
         end else if (w_tileEnd & ~w_tileValid) begin
            r_arraySel <= r_loaderSel;
         end
      end
   end

   assign bus.s_ready         = w_ready;
   assign bus.input_wr_en     = w_wordDone;
   assign bus.input_wr_addr   = r_wrAddr;
   assign bus.input_wr_data   = r_wrData;
   assign bus.input_wr_mask   = r_wrMask;
   assign bus.loader_bank_sel = r_loaderSel;
   assign bus.array_bank_sel  = r_arraySel;
   assign bus.tile_valid      = w_tileValid;
   assign bus.tile_words      = w_tileValid ? r_count[r_arraySel] : '0;
endmodule

// File: tb/tb_input_tile_loader.sv
// tb_input_tile_loader
// Directed streaming, a table of cycle vectors for the bank hand-over corner
// cases, a mid-word reset and a randomized run, all checked against a
// tile/bank counting model of the ping-pong buffer.
module tb_input_tile_loader;
   localparam int AW = 8;
   localparam int SW = 32;
   localparam int TW = 64;
   localparam int BY = SW / 8;
`ifdef LOADER_ZERO_PAD_EN
   localparam bit PAD   = 1'b1;
   localparam int PART2 = 15;
`else
   localparam bit PAD   = 1'b0;
   localparam int PART2 = 3;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   nChecks = 0;
   int   nFail   = 0;
   int   wrCount = 0;

   input_tile_loader_if #(.ADDR_WIDTH(AW), .SRAM_WIDTH(SW)) bus ();

   input_tile_loader #(.ADDR_WIDTH(AW), .SRAM_WIDTH(SW), .TILE_WORDS(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [7:0]    d;
      logic          l;
      logic          dn;
      logic          eRdy;
      logic          eWen;
      logic          eLsel;
      logic          eAsel;
      logic          eTv;
      logic [AW:0]   eTw;
      logic          chkPay;
      logic [AW-1:0] eAddr;
      logic [BY-1:0] eMask;
   } vec_t;

   function automatic vec_t mk(int v, int d, int l, int dn, int rdy, int wen, int lsel,
                               int asel, int tv, int tw, int chk, int addr, int mask);
      vec_t r;
      r.v = v[0];  r.d = d[7:0];  r.l = l[0];  r.dn = dn[0];
      r.eRdy = rdy[0];  r.eWen = wen[0];  r.eLsel = lsel[0];  r.eAsel = asel[0];
      r.eTv = tv[0];  r.eTw = tw[AW:0];  r.chkPay = chk[0];
      r.eAddr = addr[AW-1:0];  r.eMask = mask[BY-1:0];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the active edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic dn);
      @(posedge clk);
      #1;
      bus.s_valid    = v;
      bus.s_data     = d;
      bus.s_last     = l;
      bus.array_done = dn;
   endtask

   // Offer one byte until the loader takes it, with a bounded wait.
   task automatic sendByte(input logic [7:0] d, input logic l);
      int guard;
      applyStimulus(1'b1, d, l, 1'b0);
      @(negedge clk);
      guard = 0;
      while (bus.s_ready !== 1'b1 && guard < 200) begin
         applyStimulus(1'b1, d, l, 1'b0);
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) checkOutput("handshake timeout", 64'(guard), 64'(0));
   endtask

   // Reference model: tiles completed/released, bytes and words of the tile in progress.
   bit            mStarted;
   int            mCompleted, mReleased, mBytes, mWords;
   int            mLen [2];
   logic [SW-1:0] mWord;
   bit            pendValid;
   logic [AW-1:0] pendAddr;
   logic [SW-1:0] pendData;
   logic [BY-1:0] pendMask;
   bit            eTv, eReady, eAsel, eLsel, eWen;
   logic [AW:0]   eTw;
   logic [SW-1:0] bm;

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("reset s_ready", 64'(bus.s_ready), 64'(0));
         checkOutput("reset wr_en", 64'(bus.input_wr_en), 64'(0));
         checkOutput("reset wr_addr", 64'(bus.input_wr_addr), 64'(0));
         checkOutput("reset wr_data", 64'(bus.input_wr_data), 64'(0));
         checkOutput("reset wr_mask", 64'(bus.input_wr_mask), 64'(0));
         checkOutput("reset loader_bank_sel", 64'(bus.loader_bank_sel), 64'(0));
         checkOutput("reset array_bank_sel", 64'(bus.array_bank_sel), 64'(1));
         checkOutput("reset tile_valid", 64'(bus.tile_valid), 64'(0));
         checkOutput("reset tile_words", 64'(bus.tile_words), 64'(0));
         mStarted = 0;  mCompleted = 0;  mReleased = 0;  mBytes = 0;  mWords = 0;
         mLen[0] = 0;  mLen[1] = 0;  mWord = '0;  pendValid = 0;
      end else begin
         eTv    = (mCompleted > mReleased);
         eReady = mStarted && ((mCompleted - mReleased) < 2);
         eAsel  = (mCompleted == 0 && mReleased == 0) ? 1'b1 : (mReleased % 2 == 1);
         eLsel  = (((mCompleted < mReleased + 2) ? mCompleted : mReleased + 1) % 2) == 1;
         eTw    = eTv ? (AW+1)'(mLen[mReleased % 2]) : '0;
         eWen   = bus.s_valid && eReady && (mBytes == BY - 1 || bus.s_last);
         checkOutput("model s_ready", 64'(bus.s_ready), 64'(eReady));
         checkOutput("model wr_en", 64'(bus.input_wr_en), 64'(eWen));
         checkOutput("model loader_bank_sel", 64'(bus.loader_bank_sel), 64'(eLsel));
         checkOutput("model array_bank_sel", 64'(bus.array_bank_sel), 64'(eAsel));
         checkOutput("model tile_valid", 64'(bus.tile_valid), 64'(eTv));
         checkOutput("model tile_words", 64'(bus.tile_words), 64'(eTw));
         if (pendValid) begin
            for (int k = 0; k < BY; k++) bm[8*k +: 8] = {8{pendMask[k]}};
            checkOutput("model wr_addr", 64'(bus.input_wr_addr), 64'(pendAddr));
            checkOutput("model wr_mask", 64'(bus.input_wr_mask), 64'(pendMask));
            checkOutput("model wr_data", 64'(bus.input_wr_data & bm), 64'(pendData & bm));
         end
         pendValid = 0;
         if (bus.input_wr_en === 1'b1) wrCount++;
         if (bus.s_valid && eReady) begin
            mWord[8*mBytes +: 8] = bus.s_data;
            mBytes++;
            if (mBytes == BY || bus.s_last) begin
               pendValid = 1;
               pendAddr  = AW'(mWords);
               pendData  = mWord;
               pendMask  = PAD ? '1 : BY'((1 << mBytes) - 1);
               mWords++;
               mWord  = '0;
               mBytes = 0;
               if (mWords == TW || bus.s_last) begin
                  mLen[mCompleted % 2] = mWords;
                  mCompleted++;
                  mWords = 0;
               end
            end
         end
         if (bus.array_done && eTv) mReleased++;
         mStarted = 1;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      vec_t tbl [16];
      logic v, l, dn;

      tbl[0]  = mk(1, 8'hA0, 0, 0,  1, 0, 1, 0, 1, 64, 0, 0, 0);
      tbl[1]  = mk(1, 8'hA1, 0, 0,  1, 0, 1, 0, 1, 64, 0, 0, 0);
      tbl[2]  = mk(1, 8'hA2, 0, 0,  1, 0, 1, 0, 1, 64, 0, 0, 0);
      tbl[3]  = mk(1, 8'hA3, 0, 0,  1, 1, 1, 0, 1, 64, 0, 0, 0);
      tbl[4]  = mk(1, 8'hA4, 0, 0,  1, 0, 1, 0, 1, 64, 1, 0, 15);
      tbl[5]  = mk(1, 8'hA5, 1, 0,  1, 1, 1, 0, 1, 64, 0, 0, 0);
      tbl[6]  = mk(0, 8'h00, 0, 0,  0, 0, 1, 0, 1, 64, 1, 1, PART2);
      tbl[7]  = mk(1, 8'hB0, 0, 0,  0, 0, 1, 0, 1, 64, 0, 0, 0);
      tbl[8]  = mk(1, 8'hB0, 0, 1,  0, 0, 1, 0, 1, 64, 0, 0, 0);
      tbl[9]  = mk(1, 8'hB0, 0, 0,  1, 0, 0, 1, 1, 2,  0, 0, 0);
      tbl[10] = mk(1, 8'hB1, 1, 1,  1, 1, 0, 1, 1, 2,  0, 0, 0);
      tbl[11] = mk(0, 8'h00, 0, 0,  1, 0, 1, 0, 1, 1,  1, 0, PART2);
      tbl[12] = mk(0, 8'h00, 0, 1,  1, 0, 1, 0, 1, 1,  0, 0, 0);
      tbl[13] = mk(0, 8'h00, 0, 0,  1, 0, 1, 1, 0, 0,  0, 0, 0);
      tbl[14] = mk(0, 8'h00, 0, 1,  1, 0, 1, 1, 0, 0,  0, 0, 0);
      tbl[15] = mk(0, 8'h00, 0, 0,  1, 0, 1, 1, 0, 0,  0, 0, 0);

      rst_n = 1'b0;
      bus.s_valid = 1'b0;  bus.s_data = 8'h00;  bus.s_last = 1'b0;  bus.array_done = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset loader_bank_sel", 64'(bus.loader_bank_sel), 64'(0));
      checkOutput("reset array_bank_sel", 64'(bus.array_bank_sel), 64'(1));
      checkOutput("reset tile_valid", 64'(bus.tile_valid), 64'(0));
      checkOutput("reset s_ready", 64'(bus.s_ready), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      wrCount = 0;

      $display("[TB] full tile of 256 bytes");
      for (int i = 0; i < 256; i++) begin
         sendByte(8'(i), 1'b0);
         if (i == 4) begin
            checkOutput("word0 addr", 64'(bus.input_wr_addr), 64'(0));
            checkOutput("word0 data", 64'(bus.input_wr_data), 64'h03020100);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("tile0 write count", 64'(wrCount), 64'(64));
      checkOutput("word63 addr", 64'(bus.input_wr_addr), 64'(63));
      checkOutput("word63 data", 64'(bus.input_wr_data), 64'hFFFEFDFC);
      checkOutput("tile0 tile_valid", 64'(bus.tile_valid), 64'(1));
      checkOutput("tile0 tile_words", 64'(bus.tile_words), 64'(64));
      checkOutput("tile0 loader_bank_sel", 64'(bus.loader_bank_sel), 64'(1));
      checkOutput("tile0 array_bank_sel", 64'(bus.array_bank_sel), 64'(0));

      $display("[TB] short tile, bank wait and hand-over vectors");
      for (int r = 0; r < 16; r++) begin
         applyStimulus(tbl[r].v, tbl[r].d, tbl[r].l, tbl[r].dn);
         @(negedge clk);
         checkOutput($sformatf("vec%0d s_ready", r), 64'(bus.s_ready), 64'(tbl[r].eRdy));
         checkOutput($sformatf("vec%0d wr_en", r), 64'(bus.input_wr_en), 64'(tbl[r].eWen));
         checkOutput($sformatf("vec%0d loader_bank_sel", r), 64'(bus.loader_bank_sel), 64'(tbl[r].eLsel));
         checkOutput($sformatf("vec%0d array_bank_sel", r), 64'(bus.array_bank_sel), 64'(tbl[r].eAsel));
         checkOutput($sformatf("vec%0d tile_valid", r), 64'(bus.tile_valid), 64'(tbl[r].eTv));
         checkOutput($sformatf("vec%0d tile_words", r), 64'(bus.tile_words), 64'(tbl[r].eTw));
         if (tbl[r].chkPay) begin
            checkOutput($sformatf("vec%0d wr_addr", r), 64'(bus.input_wr_addr), 64'(tbl[r].eAddr));
            checkOutput($sformatf("vec%0d wr_mask", r), 64'(bus.input_wr_mask), 64'(tbl[r].eMask));
         end
      end

      $display("[TB] reset in the middle of a word");
      sendByte(8'hC0, 1'b0);
      sendByte(8'hC1, 1'b0);
      checkOutput("midword wr_en", 64'(bus.input_wr_en), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("midreset wr_en", 64'(bus.input_wr_en), 64'(0));
      checkOutput("midreset tile_valid", 64'(bus.tile_valid), 64'(0));
      checkOutput("midreset loader_bank_sel", 64'(bus.loader_bank_sel), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      wrCount = 0;
      sendByte(8'hD0, 1'b0);
      sendByte(8'hD1, 1'b0);
      sendByte(8'hD2, 1'b0);
      sendByte(8'hD3, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("post-reset write count", 64'(wrCount), 64'(1));
      checkOutput("post-reset wr_addr", 64'(bus.input_wr_addr), 64'(0));
      checkOutput("post-reset wr_data", 64'(bus.input_wr_data), 64'hD3D2D1D0);
      checkOutput("post-reset wr_mask", 64'(bus.input_wr_mask), 64'hF);
      checkOutput("post-reset tile_words", 64'(bus.tile_words), 64'(1));
      checkOutput("post-reset array_bank_sel", 64'(bus.array_bank_sel), 64'(0));

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         bit longMode;
         longMode = (c >= 1000 && c < 2000);
         v  = ($urandom % 10) < 7;
         l  = !longMode && (($urandom % 12) == 0);
         dn = longMode ? (($urandom % 40) == 0) : (($urandom % 6) == 0);
         applyStimulus(v, 8'($urandom), l, dn);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
